// File: rtl/cpu_dbg_pkg.sv
// cpu_dbg_pkg: shared definitions for the CPU debug / trace blocks.
//   TRACE_DATA_W  - default width of the PC, instruction and ALU-result fields
//   TRACE_ST_W    - width of the CPU FSM state field
//   trace_entry_t - one captured sample {pc, instr, alu, state} at default widths
//   trace_state_e - capture FSM states
package cpu_dbg_pkg;

    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_ST_W   = 3;

    typedef struct packed {
        logic [TRACE_DATA_W-1:0] pc;
        logic [TRACE_DATA_W-1:0] instr;
        logic [TRACE_DATA_W-1:0] alu;
        logic [TRACE_ST_W-1:0]   state;
    } trace_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// cpu_trace_buffer_if: sample bus and readout handshake of the trace buffer.
//   sample_en, s_pc, s_instr, s_alu, s_state  - per-instruction debug sample (CPU side)
//   rd_req                                    - request next buffered entry
//   rd_valid, rd_pc, rd_instr, rd_alu,
//   rd_state, rd_last                         - registered readout of one entry
// Modports: master = CPU/host side, slave = trace buffer.
interface cpu_trace_buffer_if #(
    parameter int DATA_W = cpu_dbg_pkg::TRACE_DATA_W,
    parameter int ST_W   = cpu_dbg_pkg::TRACE_ST_W
);
    logic              sample_en;
    logic [DATA_W-1:0] s_pc;
    logic [DATA_W-1:0] s_instr;
    logic [DATA_W-1:0] s_alu;
    logic [ST_W-1:0]   s_state;

    logic              rd_req;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_pc;
    logic [DATA_W-1:0] rd_instr;
    logic [DATA_W-1:0] rd_alu;
    logic [ST_W-1:0]   rd_state;
    logic              rd_last;

    modport master (
        output sample_en, s_pc, s_instr, s_alu, s_state, rd_req,
        input  rd_valid, rd_pc, rd_instr, rd_alu, rd_state, rd_last
    );

    modport slave (
        input  sample_en, s_pc, s_instr, s_alu, s_state, rd_req,
        output rd_valid, rd_pc, rd_instr, rd_alu, rd_state, rd_last
    );
endinterface

// File: rtl/trace_ram.sv
// trace_ram: simple dual-port storage for captured trace entries.
//   clk          - rising-edge clock
//   reset        - asynchronous active-low; clears only the read-data register
//   we/waddr/wdata - synchronous write port
//   re/raddr     - read request; data appears on rdata one cycle later
//   rdata        - registered read data, holds its value when re is low
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 99
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // NOTE: the storage array is deliberately left without a reset so it can
    // map onto RAM macros; only the read register, which drives outputs, is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // NOTE: every variable written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample their inputs from before the clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular trace capture for the multi-cycle CPU.
// Samples {pc, instr, alu, state} on each sample_en while armed, stops a fixed
// number of samples after a PC-match trigger, then reads the frozen history
// out oldest-first through a request/valid handshake.
//   clk, reset      - clock, asynchronous active-low reset
//   arm             - start capture (IDLE only)
//   abort           - return to IDLE from any state, discarding the capture
//   trig_pc         - PC value that triggers capture
//   bus (slave)     - sample inputs and readout handshake
//   busy            - ARMED or POST
//   triggered       - POST or DONE
//   done            - DONE, history ready for readout
//   fill_count      - valid entries, saturating at DEPTH
module cpu_trace_buffer
    import cpu_dbg_pkg::*;
#(
    parameter int DATA_W   = TRACE_DATA_W,
    parameter int DEPTH    = 16,
    parameter int PRE_TRIG = 4,
    parameter int ST_W     = TRACE_ST_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [DATA_W-1:0]      trig_pc,
    cpu_trace_buffer_if.slave      bus,
    output logic                   busy,
    output logic                   triggered,
    output logic                   done,
    output logic [$clog2(DEPTH):0] fill_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    // Samples still taken after the trigger sample.
    localparam logic [AW-1:0] POST_N   = AW'(DEPTH - PRE_TRIG - 1);

    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] alu;
        logic [ST_W-1:0]   state;
    } entry_t;

    trace_state_e  state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q, fill_d;
    logic [AW-1:0] post_q, post_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;   // entries requested so far
    logic          rd_valid_q, rd_valid_d;
    logic          rd_last_q, rd_last_d;

    logic   do_write;
    logic   pc_hit;
    logic   do_read;
    logic   clear;
    entry_t wr_entry;
    entry_t rd_entry;

    // Writes are blocked on an abort cycle; the capture is discarded anyway.
    assign do_write = bus.sample_en && !abort &&
                      (state_q == ST_ARMED || state_q == ST_POST);
    assign pc_hit   = bus.sample_en && !abort && (state_q == ST_ARMED) &&
                      (bus.s_pc == trig_pc);
    // Requests past the last valid entry are ignored.
    assign do_read  = bus.rd_req && !abort && (state_q == ST_DONE) &&
                      (rd_cnt_q < fill_q);
    // Counters restart on abort, on arm, and after the final entry is delivered.
    assign clear    = abort || (state_q == ST_IDLE && arm) ||
                      (state_q == ST_DONE && rd_last_q);

    assign wr_entry = '{pc: bus.s_pc, instr: bus.s_instr, alu: bus.s_alu, state: bus.s_state};

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (do_write),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .re    (do_read),
        .raddr (rd_ptr_q),
        .rdata (rd_entry)
    );

    // State register and datapath flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            post_q     <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            post_q     <= post_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (arm) state_d = ST_ARMED;
                ST_ARMED: if (pc_hit) state_d = (POST_N == '0) ? ST_DONE : ST_POST;
                ST_POST:  if (do_write && post_q == AW'(1)) state_d = ST_DONE;
                ST_DONE:  if (rd_last_q) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Pointers, counters and readout handshake.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fill_d     = fill_q;
        post_d     = post_q;
        rd_cnt_d   = rd_cnt_q;
        rd_valid_d = do_read;
        rd_last_d  = do_read && (rd_cnt_q == fill_q - CW'(1));

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            post_d   = '0;
            rd_cnt_d = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (fill_q != FULL_CNT) begin
                    fill_d = fill_q + CW'(1);
                end
            end

            if (pc_hit) begin
                post_d = POST_N;
            end else if (do_write && state_q == ST_POST) begin
                post_d = post_q - AW'(1);
            end

            // Once wrapped, the next write slot holds the oldest entry.
            if (state_q != ST_DONE && state_d == ST_DONE) begin
                rd_ptr_d = (fill_d == FULL_CNT) ? wr_ptr_d : '0;
                rd_cnt_d = '0;
            end

            if (do_read) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                rd_cnt_d = rd_cnt_q + CW'(1);
            end
        end
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy      = 1'b0;
        triggered = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_ARMED: busy = 1'b1;
            ST_POST: begin
                busy      = 1'b1;
                triggered = 1'b1;
            end
            ST_DONE: begin
                triggered = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign fill_count   = fill_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.rd_pc    = rd_entry.pc;
    assign bus.rd_instr = rd_entry.instr;
    assign bus.rd_alu   = rd_entry.alu;
    assign bus.rd_state = rd_entry.state;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: self-checking bench for cpu_trace_buffer (DEPTH=8, PRE_TRIG=3).
// Captured samples go into a scoreboard queue as they are driven; the readout
// pops and compares them oldest-first.
module tb_cpu_trace_buffer;
    import cpu_dbg_pkg::*;

    localparam int DEPTH    = 8;
    localparam int PRE_TRIG = 3;
    localparam int DATA_W   = TRACE_DATA_W;
    localparam int ST_W     = TRACE_ST_W;
    localparam int CW       = $clog2(DEPTH) + 1;

    typedef struct {
        logic              en;
        logic [DATA_W-1:0] pc;
        logic              busy;
        logic              trig;
        logic              done;
        int                fill;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              arm;
    logic              abort;
    logic [DATA_W-1:0] trig_pc;
    logic              busy;
    logic              triggered;
    logic              done;
    logic [CW-1:0]     fill_count;

    cpu_trace_buffer_if #(.DATA_W(DATA_W), .ST_W(ST_W)) bus ();

    cpu_trace_buffer #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .PRE_TRIG (PRE_TRIG),
        .ST_W     (ST_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .arm        (arm),
        .abort      (abort),
        .trig_pc    (trig_pc),
        .bus        (bus),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done),
        .fill_count (fill_count)
    );

    always #5 clk = ~clk;

    int           n_vec  = 0;
    int           n_miss = 0;
    vec_t         vecs[$];
    trace_entry_t sb[$];
    logic         cap_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic trace_entry_t mk_entry(input logic [DATA_W-1:0] pc);
        trace_entry_t e;
        e.pc    = pc;
        e.instr = {pc[15:0], ~pc[15:0]};
        e.alu   = pc * 32'd3 + 32'd1;
        e.state = pc[4:2];
        return e;
    endfunction

    // Drive one sample for one clock; called and returning at a falling edge.
    task automatic step(input logic en, input logic [DATA_W-1:0] pc);
        trace_entry_t e;
        e = mk_entry(pc);
        bus.sample_en = en;
        bus.s_pc      = e.pc;
        bus.s_instr   = e.instr;
        bus.s_alu     = e.alu;
        bus.s_state   = e.state;
        if (en && cap_on) begin
            sb.push_back(e);
            if (sb.size() > DEPTH) sb.delete(0);
        end
        @(negedge clk);
        bus.sample_en = 1'b0;
    endtask

    task automatic arm_capture(input logic [DATA_W-1:0] tpc);
        trig_pc = tpc;
        arm     = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("arm_busy", busy, 1);
        check("arm_fill", fill_count, 0);
        sb.delete();
        cap_on = 1'b1;
    endtask

    // Drain the whole capture with rd_req held high, then check return to IDLE.
    task automatic readout(input int trig_idx);
        trace_entry_t      e;
        int                budget;
        int                idx;
        logic [DATA_W-1:0] last_pc;
        budget  = 0;
        idx     = 0;
        last_pc = '0;
        bus.rd_req = 1'b1;
        while (sb.size() > 0 && budget < 4 * DEPTH) begin
            @(negedge clk);
            budget++;
            if (bus.rd_valid) begin
                e = sb.pop_front();
                check("rd_pc", bus.rd_pc, e.pc);
                check("rd_instr", bus.rd_instr, e.instr);
                check("rd_alu", bus.rd_alu, e.alu);
                check("rd_state", bus.rd_state, e.state);
                check("rd_last", bus.rd_last, sb.size() == 0);
                if (idx == trig_idx) check("rd_trig_pos", bus.rd_pc, trig_pc);
                last_pc = e.pc;
                idx++;
            end
        end
        check("rd_drain", sb.size(), 0);
        // rd_req is still high here and must be ignored.
        @(negedge clk);
        check("end_rd_valid", bus.rd_valid, 0);
        check("end_done", done, 0);
        check("end_triggered", triggered, 0);
        check("end_fill", fill_count, 0);
        check("end_hold_pc", bus.rd_pc, last_pc);
        bus.rd_req = 1'b0;
    endtask

    task automatic run_full();
        arm_capture(32'h28);
        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].pc);
            check("cap_busy", busy, vecs[i].busy);
            check("cap_trig", triggered, vecs[i].trig);
            check("cap_done", done, vecs[i].done);
            check("cap_fill", fill_count, vecs[i].fill);
            if (vecs[i].done) cap_on = 1'b0;
        end
        readout(PRE_TRIG);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        trace_entry_t e;
        int           w;
        int           nv;
        int           budget;

        // Full-capture table: pc = 4k, k = 0..14, trigger at 0x28 (k = 10).
        // Three unstrobed cycles with s_pc = 0x28 are inserted before k = 6.
        w = 0;
        for (int k = 0; k < 15; k++) begin
            if (k == 6) begin
                for (int g = 0; g < 3; g++) begin
                    vecs.push_back('{en: 1'b0, pc: 32'h28, busy: 1'b1, trig: 1'b0,
                                     done: 1'b0, fill: w});
                end
            end
            w++;
            vecs.push_back('{en: 1'b1, pc: 32'(4 * k), busy: (k < 14), trig: (k >= 10),
                             done: (k >= 14), fill: (w > DEPTH) ? DEPTH : w});
        end

        reset         = 1'b0;
        arm           = 1'b1;
        abort         = 1'b0;
        trig_pc       = '0;
        bus.sample_en = 1'b0;
        bus.s_pc      = '0;
        bus.s_instr   = '0;
        bus.s_alu     = '0;
        bus.s_state   = '0;
        bus.rd_req    = 1'b0;

        // Reset held for 30 ns with arm asserted.
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_fill", fill_count, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_last", bus.rd_last, 0);
        check("rst_rd_pc", bus.rd_pc, 0);
        arm   = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", busy, 0);

        // IDLE ignores rd_req and sample_en.
        bus.rd_req = 1'b1;
        step(1'b1, 32'h28);
        bus.rd_req = 1'b0;
        check("idle_rd_valid", bus.rd_valid, 0);
        check("idle_fill", fill_count, 0);
        check("idle_busy", busy, 0);

        // Full capture with gapped sampling.
        run_full();

        // Early trigger at k = 1: DONE after k = 5 with 6 entries.
        arm_capture(32'h04);
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 32'(4 * k));
            check("early_trig", triggered, k >= 1);
            check("early_done", done, k >= 5);
            check("early_fill", fill_count, (k >= 5) ? 6 : k + 1);
            if (k == 5) cap_on = 1'b0;
        end
        readout(1);

        // Abort in POST after the trigger and two post samples.
        arm_capture(32'h28);
        for (int k = 0; k < 13; k++) step(1'b1, 32'(4 * k));
        check("abort_pre_trig", triggered, 1);
        check("abort_pre_busy", busy, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_triggered", triggered, 0);
        check("abort_done", done, 0);
        check("abort_fill", fill_count, 0);
        sb.delete();
        cap_on = 1'b0;

        // arm together with abort: abort wins.
        arm   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_abort_busy", busy, 0);

        // Re-arm repeats the full-capture result.
        run_full();

        // Reset during readout after three valid entries.
        arm_capture(32'h04);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 32'(4 * k));
            if (k == 5) cap_on = 1'b0;
        end
        check("mr_done", done, 1);
        bus.rd_req = 1'b1;
        nv     = 0;
        budget = 0;
        while (nv < 3 && budget < 20) begin
            @(negedge clk);
            budget++;
            if (bus.rd_valid) begin
                e = sb.pop_front();
                check("mr_rd_pc", bus.rd_pc, e.pc);
                nv++;
            end
        end
        check("mr_valids", nv, 3);
        #1 reset = 1'b0;
        #1;
        check("mr_rd_valid", bus.rd_valid, 0);
        check("mr_done_rst", done, 0);
        check("mr_rd_pc_rst", bus.rd_pc, 0);
        check("mr_rd_instr_rst", bus.rd_instr, 0);
        check("mr_rd_alu_rst", bus.rd_alu, 0);
        check("mr_rd_state_rst", bus.rd_state, 0);
        check("mr_triggered", triggered, 0);
        check("mr_fill", fill_count, 0);
        bus.rd_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mr_idle_busy", busy, 0);
        check("mr_idle_done", done, 0);
        check("mr_idle_rd_valid", bus.rd_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised trace-capture block for the multi-cycle CPU, succeeding the free-running simulation top. It samples per-instruction debug signals (PC, instruction, ALU result, FSM state) into a circular buffer. Capture is armed by software or the bench and stops a fixed number of samples after a PC-match trigger. The frozen history is then read out oldest-first through a request/valid handshake. It sits beside the CPU core, fed from the core's debug outputs, with sample_en driven by PCWrite.

Parameters:
DATA_W, 32, width of PC, instruction and ALU-result fields
DEPTH, 16, buffer entries; power of two, minimum 4
PRE_TRIG, 4, entries kept before the trigger sample when the buffer is full; must be less than DEPTH
ST_W, 3, width of the CPU state field

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
arm  in  1  start capture; honoured only in IDLE
abort  in  1  return to IDLE from any state; buffer contents discarded
trig_pc  in  DATA_W  PC value that triggers capture
sample_en  in  1  sample strobe (PCWrite)
s_pc  in  DATA_W  current PC
s_instr  in  DATA_W  current instruction
s_alu  in  DATA_W  ALU result
s_state  in  ST_W  CPU FSM state
rd_req  in  1  request next entry; honoured only in DONE
rd_valid  out  1  one-cycle pulse, read fields valid
rd_pc  out  DATA_W  read-out PC
rd_instr  out  DATA_W  read-out instruction
rd_alu  out  DATA_W  read-out ALU result
rd_state  out  ST_W  read-out CPU state
rd_last  out  1  qualifies rd_valid on the final entry
busy  out  1  high in ARMED or POST
triggered  out  1  high in POST and DONE
done  out  1  high in DONE
fill_count  out  clog2(DEPTH)+1  valid entries, saturates at DEPTH

Behaviour:
- Reset (reset=0, async): state=IDLE; wr_ptr, rd_ptr, fill_count, post counter = 0. All outputs are 0. Buffer RAM is not reset.
- FSM states: IDLE, ARMED, POST, DONE.
  - IDLE: arm=1 moves to ARMED next cycle and clears fill_count and wr_ptr. sample_en is ignored.
  - ARMED: each sample_en writes {s_pc,s_instr,s_alu,s_state} at wr_ptr. wr_ptr increments mod DEPTH. fill_count increments, saturating at DEPTH.
  - Trigger condition: ARMED, sample_en=1 and s_pc==trig_pc. The trigger sample is written. Move to POST with post counter = POST_N = DEPTH-PRE_TRIG-1.
  - Trigger is honoured even if fill_count < PRE_TRIG; fewer pre-trigger entries then exist.
  - POST: each sample_en writes and decrements the counter. PC matches are ignored.
  - POST exit: the write that takes the counter to 0 moves to DONE on the same edge. If POST_N=0, the trigger goes straight to DONE.
  - DONE: sampling stops. Start address is rd_ptr = wr_ptr if fill_count==DEPTH, else 0.
- Readout (DONE only):
  - rd_req=1 reads entry rd_ptr. rd_valid plus fields are registered one cycle after rd_req.
  - rd_ptr increments mod DEPTH. rd_req may be asserted on consecutive cycles.
  - rd_last=1 with the fill_count-th entry. rd_req is ignored once the last entry has been requested.
  - The cycle after rd_last the FSM enters IDLE; done, triggered and fill_count go to 0.
- When full, the trigger entry is at readout index PRE_TRIG (0-based).
- abort: highest priority after reset, synchronous. Next state is IDLE with counters cleared; an in-flight rd_valid still completes.
- arm together with abort: abort wins.
- Read fields hold their last value while rd_valid=0.
- PC comparison is full DATA_W, exact equality.

Decomposition:
- Shared package cpu_dbg_pkg: trace-entry struct {pc,instr,alu,state}, FSM state enum, TRACE_ST_W constant.
- One sub-module trace_ram: simple dual-port RAM, one write port and one registered read port, DEPTH x entry width.
- FSM and pointers live in the top.

Test Plan:
- Reset: hold reset=0 for 30 ns with clocks running -> all outputs 0, busy=0, fill_count=0. arm during reset has no effect.
- Full capture (DEPTH=8, PRE_TRIG=3): arm, samples s_pc=4k for k=0..14, trig_pc=0x28 -> done after the k=14 sample, fill_count=8. Readout gives PCs 0x1C,0x20,0x24,0x28,0x2C,0x30,0x34,0x38, with rd_last on 0x38, then IDLE.
- Early trigger: trig_pc=0x04, samples k=0..9 -> done after k=5, fill_count=6. Readout gives 0x00..0x14, with rd_last on the 6th entry.
- Gapped sampling: sample_en low for 3 cycles while s_pc=0x28 -> no write and no trigger. Trigger fires only on the strobed cycle.
- Abort in POST: after the trigger and 2 post samples, pulse abort -> IDLE next cycle, triggered=0, fill_count=0. A re-arm then repeats the full-capture result.
- Reset mid-readout: drop reset after 3 rd_valid pulses -> rd_valid, done and rd_* immediately 0, state IDLE.
